// File: rtl/de_pkg.sv
// Shared types and constants for the difference-engine sweep controller.
package de_pkg;

  localparam int N_W       = 6;
  localparam int RES_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DWELL,
    ST_FINISH
  } state_t;

  // Bits needed to hold a load value of (count - 1) for the larger of two counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/de_dwell_timer.sv
// Loadable down-counter that stops at zero; o_zero flags the terminal count.
module de_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/de_sweep_ctrl.sv
// Sweeps n over [n_first, n_last], launching the difference engine and holding each result for DWELL cycles.
// Optional WAIT timeout enabled by defining DE_SWEEP_TIMEOUT_EN.
module de_sweep_ctrl
  import de_pkg::*;
#(
  parameter int RES_W   = RES_W_DEF,
  parameter int DWELL   = 50_000_000,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic [N_W-1:0]   n_first,
  input  logic [N_W-1:0]   n_last,
  output logic [N_W-1:0]   de_n,
  output logic             de_start,
  input  logic             de_done,
  input  logic [RES_W-1:0] de_result,
  output logic [RES_W-1:0] disp_value,
  output logic             disp_valid,
  output logic             busy,
  output logic             sweep_done,
  output logic             error
);

  // The single timer serves both the dwell and the optional timeout, so it is sized for either.
  localparam int CNT_W = cnt_width(DWELL, TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_go_d;
  logic [N_W-1:0]   r_n_last;
  logic [N_W-1:0]   r_de_n;
  logic [RES_W-1:0] r_disp_value;
  logic             r_disp_valid;
  logic             r_error;

  logic             w_go_rise;
  logic             w_range_ok;
  logic             w_accept;
  logic             w_abort;
  logic             w_capture;
  logic             w_advance;
  logic             w_timeout;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;
  logic             w_de_start;
  logic             w_busy;
  logic             w_sweep_done;

  assign w_go_rise  = go & ~r_go_d;
  assign w_range_ok = (n_first <= n_last);
  assign w_accept   = (r_state == ST_IDLE) && w_go_rise;
  assign w_abort    = abort && (r_state != ST_IDLE);

  de_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_en    = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_rise && w_range_ok) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT;
`ifdef DE_SWEEP_TIMEOUT_EN
        w_tmr_load  = 1'b1;
        w_tmr_val   = CNT_W'(TIMEOUT - 1);
`endif
      end
      ST_WAIT: begin
`ifdef DE_SWEEP_TIMEOUT_EN
        w_tmr_en = 1'b1;
`endif
        if (de_done) begin
          w_capture   = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(DWELL - 1);
          w_state_nxt = ST_DWELL;
        end
`ifdef DE_SWEEP_TIMEOUT_EN
        else if (w_tmr_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_DWELL: begin
        w_tmr_en = 1'b1;
        // End test comes before the increment so n_last = 63 never wraps de_n.
        if (w_tmr_zero) begin
          if (r_de_n == r_n_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything, including a de_done in the same cycle.
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_timeout   = 1'b0;
      w_tmr_load  = 1'b0;
    end
  end

  always_comb begin
    w_de_start   = 1'b0;
    w_sweep_done = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE:   w_busy       = 1'b0;
      ST_LAUNCH: w_de_start   = 1'b1;
      ST_FINISH: w_sweep_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_go_d       <= 1'b0;
      r_n_last     <= '0;
      r_de_n       <= '0;
      r_disp_value <= '0;
      r_disp_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_go_d <= go;
      if (w_accept) begin
        r_n_last     <= n_last;
        r_error      <= ~w_range_ok;
        r_disp_valid <= 1'b0;
        if (w_range_ok) r_de_n <= n_first;
      end
      if (w_capture) begin
        r_disp_value <= de_result;
        r_disp_valid <= 1'b1;
      end
      if (w_advance) r_de_n <= r_de_n + N_W'(1);
      if (w_timeout) begin
        r_error      <= 1'b1;
        r_disp_valid <= 1'b0;
      end
      if (w_abort) r_disp_valid <= 1'b0;
    end
  end

  assign de_n       = r_de_n;
  assign de_start   = w_de_start;
  assign disp_value = r_disp_value;
  assign disp_valid = r_disp_valid;
  assign busy       = w_busy;
  assign sweep_done = w_sweep_done;
  assign error      = r_error;

endmodule

// File: doc/de_sweep_ctrl.md
DE_SWEEP_CTRL -- requirements
Module: de_sweep_ctrl

Interface
REQ-001 SHALL have parameter RES_W, default 16, width of the difference-engine result and display value.
REQ-002 SHALL have parameter DWELL, default 50_000_000, number of clk cycles each result is held on the display.
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000, maximum number of cycles to wait for de_done (used only when DE_SWEEP_TIMEOUT_EN is defined).
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  sweep request, rising-edge detected internally.
- abort  in  1  synchronous sweep cancel, level.
- n_first  in  6  first n of the sweep, sampled on accepted go.
- n_last  in  6  last n of the sweep, sampled on accepted go.
- de_n  out  6  n presented to the difference engine.
- de_start  out  1  one-cycle start pulse to the difference engine.
- de_done  in  1  difference-engine completion strobe.
- de_result  in  RES_W  difference-engine result, valid while de_done=1.
- disp_value  out  RES_W  value sent to the seven-segment driver.
- disp_valid  out  1  disp_value holds a current result.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- error  out  1  sticky fault flag.

Function
REQ-005 SHALL implement the FSM states IDLE, LAUNCH, WAIT, DWELL and FINISH.
REQ-006 IDLE: on a rising edge of go, SHALL latch n_first and n_last, clear error and disp_valid, and, if n_first<=n_last, load de_n=n_first and go to LAUNCH.
REQ-007 IDLE: on a rising edge of go with n_first>n_last, SHALL set error=1, issue no de_start and remain in IDLE.
REQ-008 LAUNCH: SHALL assert de_start for exactly one cycle, then go to WAIT; de_n SHALL be stable from LAUNCH until leaving DWELL.
REQ-009 WAIT: on de_done=1, SHALL capture de_result into disp_value the same edge, set disp_valid=1 and go to DWELL.
REQ-010 DWELL: SHALL remain for exactly DWELL cycles; then go to FINISH if de_n==latched n_last, else increment de_n and go to LAUNCH.
REQ-011 FINISH: SHALL pulse sweep_done for one cycle, go to IDLE and keep disp_value/disp_valid holding the last result.
REQ-012 Latency: de_start SHALL rise 1 cycle after the go edge is registered; disp_value SHALL update on the edge after de_done=1.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 A go edge while busy=1 SHALL be ignored.
REQ-015 de_done outside WAIT SHALL be ignored.
REQ-016 When n_last=63, de_n SHALL never wrap to 0; the end test SHALL precede the increment.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with de_start=0, sweep_done=0 and disp_valid=0.
REQ-018 abort SHALL take priority over a simultaneous de_done.

Reset
REQ-019 reset=0 SHALL asynchronously force state=IDLE, de_n=0, de_start=0, disp_value=0, disp_valid=0, busy=0, sweep_done=0, error=0, clear the go edge detector and clear all counters.
REQ-020 Reset SHALL take effect mid-sweep, with no de_start issued after reset is released until a new go edge.

Configuration
REQ-021 With DE_SWEEP_TIMEOUT_EN defined, SHALL count cycles in WAIT; when TIMEOUT cycles elapse with no de_done, SHALL set error=1, clear disp_valid and go to IDLE.
REQ-022 Without DE_SWEEP_TIMEOUT_EN, WAIT SHALL last indefinitely, no timeout counter SHALL be synthesized, and error SHALL be set only by REQ-007.

Structure
REQ-023 Shared package de_pkg SHALL hold the state enum, N_W=6 and the default RES_W.
REQ-024 Sub-module de_dwell_timer SHALL implement the loadable down-counter used by DWELL (and reused for the timeout when enabled).

Verification
REQ-025 Sweep: n_first=2, n_last=4, DWELL=4, engine model answering in 3 cycles -> three de_start pulses with de_n=2,3,4, disp_value updates each time, one sweep_done.
REQ-026 Range fault: n_first=5, n_last=3, go -> error=1, no de_start, busy stays 0.
REQ-027 Boundary: n_first=62, n_last=63 -> de_n=62 then 63, sweep_done, de_n never 0.
REQ-028 Abort during WAIT, with de_done asserted in the same cycle -> IDLE next cycle, disp_valid=0, no capture.
REQ-029 DE_SWEEP_TIMEOUT_EN defined, TIMEOUT=10, engine never responds -> error=1 after 10 WAIT cycles, busy=0.
REQ-030 reset=0 during DWELL, then a go edge during the sweep after release -> all outputs 0 after reset, and the go edge during the sweep is ignored.
